dma_cmd_queue: RTL and testbench



---
 rtl/dma_cmd_queue.sv | 221 ++++++++++++++++++++++
 tb/tb_dma_cmd_queue.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_cmd_queue.sv
// dma_cmd_queue: buffers DMA descriptors and replays each one as the MMIO
// register write sequence (0x10..0x24), then polls status at 0x2C until
// the DMA reports done or the poll budget runs out. Completions come back
// one per descriptor, strictly in push order.
module dma_cmd_queue #(
  parameter int DEPTH    = 4,
  parameter int POLL_GAP = 4,
  parameter int TIMEOUT  = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     desc_valid,
  output logic                     desc_ready,
  input  logic [63:0]              desc_src,
  input  logic [63:0]              desc_dst,
  input  logic [31:0]              desc_len,
  output logic                     cfg_req_valid,
  output logic [31:0]              cfg_req_addr,
  output logic [31:0]              cfg_req_wdata,
  input  logic                     cfg_resp_valid,
  input  logic [31:0]              cfg_resp_rdata,
  output logic                     cpl_valid,
  output logic                     cpl_status,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Gap counter must hold POLL_GAP; keep at least one bit when the gap is 0.
  localparam int GW = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);
  // Poll counter only ever holds 0..TIMEOUT-1; the last failed poll aborts.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR   = 3'd1;
  localparam logic [2:0] ST_GAP  = 3'd2;
  localparam logic [2:0] ST_POLL = 3'd3;
  localparam logic [2:0] ST_CPL  = 3'd4;

  localparam logic [31:0] ADDR_STATUS = 32'h0000_002C;

  logic [159:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [159:0]  head;
  logic [63:0]   head_src;
  logic [63:0]   head_dst;
  logic [31:0]   head_len;

  logic [2:0]    state;
  logic [2:0]    beat;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] poll_cnt;
  logic          cpl_stat_q;
  logic [63:0]   w_src;
  logic [63:0]   w_dst;
  logic [31:0]   w_len;

  // Only the done bit of the status word carries meaning here.
  logic          rdata_unused;
  assign rdata_unused = ^cfg_resp_rdata[31:1];

  assign desc_ready = (count < CW'(DEPTH));
  assign push       = desc_valid && desc_ready;
  assign pop        = (state == ST_IDLE) && (count != '0);

  assign head     = mem[rd_ptr];
  assign head_src = head[159:96];
  assign head_dst = head[95:32];
  assign head_len = head[31:0];

  // Address/data pair for one beat of the register write sequence.
  function automatic logic [63:0] beat_word(input logic [2:0] b,
                                            input logic [63:0] s,
                                            input logic [63:0] d,
                                            input logic [31:0] l);
    case (b)
      3'd0:    beat_word = {32'h0000_0010, s[31:0]};
      3'd1:    beat_word = {32'h0000_0014, s[63:32]};
      3'd2:    beat_word = {32'h0000_0018, d[31:0]};
      3'd3:    beat_word = {32'h0000_001C, d[63:32]};
      3'd4:    beat_word = {32'h0000_0020, l};
      default: beat_word = {32'h0000_0024, 32'h0000_0001};
    endcase
  endfunction

  // Descriptor storage; contents need no reset since pointers guard them.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {desc_src, desc_dst, desc_len};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sequencer: pops one descriptor, writes it out, waits, polls, completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      beat          <= '0;
      gap_cnt       <= '0;
      poll_cnt      <= '0;
      cpl_stat_q    <= 1'b0;
      w_src         <= '0;
      w_dst         <= '0;
      w_len         <= '0;
      cfg_req_valid <= 1'b0;
      cfg_req_addr  <= '0;
      cfg_req_wdata <= '0;
      cpl_valid     <= 1'b0;
      cpl_status    <= 1'b0;
    end else begin
      cpl_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            w_src    <= head_src;
            w_dst    <= head_dst;
            w_len    <= head_len;
            poll_cnt <= '0;
            busy     <= 1'b1;
            if (head_len == 32'd0) begin
              state      <= ST_CPL;
              cpl_stat_q <= 1'b0;
            end else begin
              state         <= ST_WR;
              beat          <= 3'd0;
              cfg_req_valid <= 1'b1;
              {cfg_req_addr, cfg_req_wdata} <= beat_word(3'd0, head_src, head_dst, head_len);
            end
          end
        end
        ST_WR: begin
          if (cfg_resp_valid) begin
            if (beat == 3'd5) begin
              if (POLL_GAP == 0) begin
                state         <= ST_POLL;
                cfg_req_addr  <= ADDR_STATUS;
                cfg_req_wdata <= '0;
              end else begin
                state         <= ST_GAP;
                gap_cnt       <= GW'(POLL_GAP);
                cfg_req_valid <= 1'b0;
                cfg_req_addr  <= '0;
                cfg_req_wdata <= '0;
              end
            end else begin
              beat <= beat + 3'd1;
              {cfg_req_addr, cfg_req_wdata} <= beat_word(beat + 3'd1, w_src, w_dst, w_len);
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GW'(1)) begin
            state         <= ST_POLL;
            gap_cnt       <= '0;
            cfg_req_valid <= 1'b1;
            cfg_req_addr  <= ADDR_STATUS;
            cfg_req_wdata <= '0;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        ST_POLL: begin
          if (cfg_resp_valid) begin
            if (cfg_resp_rdata[0]) begin
              state         <= ST_CPL;
              cpl_stat_q    <= 1'b0;
              cfg_req_valid <= 1'b0;
              cfg_req_addr  <= '0;
            end else if (poll_cnt == TW'(TIMEOUT - 1)) begin
              state         <= ST_CPL;
              cpl_stat_q    <= 1'b1;
              cfg_req_valid <= 1'b0;
              cfg_req_addr  <= '0;
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
            end
          end
        end
        ST_CPL: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          cpl_valid  <= 1'b1;
          cpl_status <= cpl_stat_q;
        end
        default: begin
          state         <= ST_IDLE;
          busy          <= 1'b0;
          cfg_req_valid <= 1'b0;
          cfg_req_addr  <= '0;
          cfg_req_wdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dma_cmd_queue.sv
// tb_dma_cmd_queue: directed scenarios for dma_cmd_queue, with a
// transaction-level model that tracks which descriptor the MMIO stream
// belongs to and what each completion must report.
module tb_dma_cmd_queue;

  localparam int DEPTH    = 4;
  localparam int POLL_GAP = 4;
  localparam int TIMEOUT  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        desc_valid;
  logic        desc_ready;
  logic [63:0] desc_src;
  logic [63:0] desc_dst;
  logic [31:0] desc_len;
  logic        cfg_req_valid;
  logic [31:0] cfg_req_addr;
  logic [31:0] cfg_req_wdata;
  logic        cfg_resp_valid;
  logic [31:0] cfg_resp_rdata;
  logic        cpl_valid;
  logic        cpl_status;
  logic        busy;
  logic [2:0]  count;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: descriptors in push order plus per-descriptor outcome.
  logic [63:0] m_src [64];
  logic [63:0] m_dst [64];
  logic [31:0] m_len [64];
  bit          st_known [64];
  bit          st_val [64];
  int n_push      = 0;
  int req_idx     = 0;
  int cpl_idx     = 0;
  int beat        = -1;
  int gap_cycles  = 0;
  int bad_polls   = 0;
  int polls_cur   = 0;
  int last_polls  = 0;
  int run18       = 0;
  int last_run18  = 0;
  int n_cpl       = 0;

  dma_cmd_queue #(
    .DEPTH(DEPTH),
    .POLL_GAP(POLL_GAP),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .desc_valid(desc_valid),
    .desc_ready(desc_ready),
    .desc_src(desc_src),
    .desc_dst(desc_dst),
    .desc_len(desc_len),
    .cfg_req_valid(cfg_req_valid),
    .cfg_req_addr(cfg_req_addr),
    .cfg_req_wdata(cfg_req_wdata),
    .cfg_resp_valid(cfg_resp_valid),
    .cfg_resp_rdata(cfg_resp_rdata),
    .cpl_valid(cpl_valid),
    .cpl_status(cpl_status),
    .busy(busy),
    .count(count)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Register address the sequence must present at a given beat (6+ = poll).
  function automatic logic [31:0] exp_addr(input int b);
    return (b < 6) ? 32'(32'h10 + 4 * b) : 32'h2C;
  endfunction

  function automatic logic [31:0] exp_data(input int b, input int idx);
    case (b)
      0:       return m_src[idx][31:0];
      1:       return m_src[idx][63:32];
      2:       return m_dst[idx][31:0];
      3:       return m_dst[idx][63:32];
      4:       return m_len[idx];
      5:       return 32'h1;
      default: return 32'h0;
    endcase
  endfunction

  task automatic finishDesc(input bit status);
    st_known[req_idx] = 1'b1;
    st_val[req_idx]   = status;
    req_idx++;
    beat       = -1;
    last_polls = polls_cur;
    last_run18 = run18;
  endtask

  // Compare process: samples every cycle 2 ns before the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        req_idx = n_push;
        cpl_idx = n_push;
        beat    = -1;
        checkOutput("rst_req_valid", cfg_req_valid, 0);
        checkOutput("rst_cpl_valid", cpl_valid, 0);
        checkOutput("rst_count", count, 0);
      end else begin
        checkOutput("ready_vs_count", desc_ready, (count < 3'(DEPTH)));
        if (cpl_valid) begin
          n_cpl++;
          if (cpl_idx < n_push && st_known[cpl_idx]) begin
            checkOutput("cpl_status", cpl_status, st_val[cpl_idx]);
            cpl_idx++;
          end else begin
            checkOutput("spurious_cpl", cpl_valid, 0);
          end
        end
        if (cfg_req_valid) begin
          checkOutput("busy_when_req", busy, 1);
          if (beat < 0) begin
            while (req_idx < n_push && m_len[req_idx] == 32'd0) req_idx++;
            if (req_idx >= n_push) begin
              checkOutput("spurious_req", cfg_req_valid, 0);
            end else begin
              checkOutput("in_order_start", cpl_idx, req_idx);
              beat      = 0;
              run18     = 0;
              polls_cur = 0;
              bad_polls = 0;
            end
          end
          if (beat >= 0) begin
            if (beat == 6) begin
              checkOutput("poll_gap", gap_cycles, POLL_GAP);
              beat = 7;
            end
            checkOutput("req_addr", cfg_req_addr, exp_addr(beat));
            checkOutput("req_wdata", cfg_req_wdata, exp_data(beat, req_idx));
            if (cfg_req_addr == 32'h18) run18++;
            if (cfg_resp_valid) begin
              if (beat < 5) begin
                beat++;
              end else if (beat == 5) begin
                beat       = 6;
                gap_cycles = 0;
              end else begin
                polls_cur++;
                if (cfg_resp_rdata[0]) begin
                  finishDesc(1'b0);
                end else begin
                  bad_polls++;
                  if (bad_polls == TIMEOUT) finishDesc(1'b1);
                end
              end
            end
          end
        end else begin
          if (beat >= 0 && beat <= 5) checkOutput("req_dropped", cfg_req_valid, 1);
          else if (beat == 6) gap_cycles++;
          else if (beat == 7) checkOutput("poll_dropped", cfg_req_valid, 1);
        end
        if (desc_valid && desc_ready) begin
          m_src[n_push]    = desc_src;
          m_dst[n_push]    = desc_dst;
          m_len[n_push]    = desc_len;
          st_known[n_push] = (desc_len == 32'd0);
          st_val[n_push]   = 1'b0;
          n_push++;
        end
      end
    end
  end

  // Offer one descriptor and hold it until it is accepted.
  task automatic applyStimulus(input logic [63:0] s, input logic [63:0] d, input logic [31:0] l);
    int waited = 0;
    @(negedge clk);
    desc_valid = 1'b1;
    desc_src   = s;
    desc_dst   = d;
    desc_len   = l;
    #3;
    while (!desc_ready && waited < 200) begin
      @(negedge clk);
      #3;
      waited++;
    end
    if (!desc_ready) checkOutput("push_accept_timeout", desc_ready, 1);
  endtask

  task automatic setResp(input logic v, input logic done);
    cfg_resp_valid = v;
    cfg_resp_rdata = 32'hDEAD_BEE0 | {31'd0, done};
  endtask

  // Counts sampled cycles until cpl_valid; the first sample is the cycle after the push.
  task automatic waitCpl(output int n);
    n = 0;
    do begin
      @(negedge clk);
      desc_valid = 1'b0;
      #3;
      n++;
    end while (!cpl_valid && n < 200);
    if (!cpl_valid) checkOutput("cpl_wait_timeout", cpl_valid, 1);
  endtask

  task automatic waitReq(input logic [31:0] a);
    int n = 0;
    do begin
      @(negedge clk);
      desc_valid = 1'b0;
      #3;
      n++;
    end while (!(cfg_req_valid && cfg_req_addr == a) && n < 100);
    if (!(cfg_req_valid && cfg_req_addr == a)) checkOutput("req_wait_timeout", {cfg_req_valid, cfg_req_addr}, {1'b1, a});
  endtask

  task automatic waitCplCount(input int target);
    int n = 0;
    while (n_cpl < target && n < 400) begin
      @(negedge clk);
      desc_valid = 1'b0;
      #3;
      n++;
    end
    checkOutput("cpl_total", n_cpl, target);
  endtask

  // Hard stop in case a scenario wedges beyond its own bounds.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios.
  initial begin
    int n;
    int snap;
    rst        = 1'b1;
    desc_valid = 1'b0;
    desc_src   = '0;
    desc_dst   = '0;
    desc_len   = '0;
    setResp(1'b1, 1'b1);

    // Reset values, sampled while reset is held.
    @(negedge clk);
    @(negedge clk);
    #3;
    checkOutput("reset_desc_ready", desc_ready, 1);
    checkOutput("reset_count", count, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_req_valid", cfg_req_valid, 0);
    checkOutput("reset_req_addr", cfg_req_addr, 0);
    checkOutput("reset_req_wdata", cfg_req_wdata, 0);
    checkOutput("reset_cpl_valid", cpl_valid, 0);
    checkOutput("reset_cpl_status", cpl_status, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #3;
    checkOutput("idle_busy", busy, 0);

    // Single descriptor: cpl_valid is the 13th cycle counting the pop cycle,
    // i.e. 14 samples after the push cycle (pop is one edge after the push).
    $display("[TB] single descriptor");
    applyStimulus(64'h1_0000_0040, 64'h2_0000_0080, 32'h100);
    waitCpl(n);
    checkOutput("single_latency", n, 14);
    checkOutput("single_status", cpl_status, 0);
    checkOutput("single_polls", last_polls, 1);

    // Zero length: no MMIO, completion two edges after the push edge.
    $display("[TB] zero length");
    applyStimulus(64'h3_0000_0000, 64'h4_0000_0000, 32'h0);
    waitCpl(n);
    checkOutput("zero_latency", n, 3);
    checkOutput("zero_status", cpl_status, 0);

    // Backpressure: three stalled cycles on beat 2 hold 0x18 for four cycles.
    $display("[TB] backpressure");
    applyStimulus(64'h0000_0005_1111_2222, 64'h0000_0006_3333_4444, 32'h40);
    waitReq(32'h14);
    @(posedge clk);
    #1;
    setResp(1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    setResp(1'b1, 1'b1);
    waitCpl(n);
    checkOutput("bp_hold_cycles", last_run18, 4);
    checkOutput("bp_status", cpl_status, 0);

    // Fill: first descriptor parked in POLL while five more are offered.
    $display("[TB] fill");
    setResp(1'b1, 1'b0);
    snap = n_cpl;
    applyStimulus(64'h10, 64'h20, 32'h1);
    waitReq(32'h24);
    @(negedge clk);
    setResp(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(64'h100 + 64'(i), 64'h200 + 64'(i), 32'h10 + 32'(i));
    end
    @(negedge clk);
    desc_valid = 1'b1;
    desc_src   = 64'h1FF;
    desc_dst   = 64'h2FF;
    desc_len   = 32'h1F;
    #3;
    checkOutput("full_count", count, 4);
    checkOutput("full_ready", desc_ready, 0);
    repeat (2) begin
      @(negedge clk);
      #3;
      checkOutput("full_hold_ready", desc_ready, 0);
    end
    @(negedge clk);
    setResp(1'b1, 1'b1);
    n = 0;
    #3;
    while (!desc_ready && n < 100) begin
      @(negedge clk);
      #3;
      n++;
    end
    checkOutput("fifth_accept_count", count, 3);
    waitCplCount(snap + 6);

    // Timeout: eight refused polls, then a normal descriptor.
    $display("[TB] timeout");
    setResp(1'b1, 1'b0);
    applyStimulus(64'hAAAA_0000_0000_1234, 64'hBBBB_0000_0000_5678, 32'h80);
    waitCpl(n);
    checkOutput("timeout_status", cpl_status, 1);
    checkOutput("timeout_polls", last_polls, 8);
    setResp(1'b1, 1'b1);
    applyStimulus(64'h7, 64'h8, 32'h9);
    waitCpl(n);
    checkOutput("after_timeout_status", cpl_status, 0);
    checkOutput("after_timeout_latency", n, 14);

    // Reset during beat 3 with two descriptors still queued.
    $display("[TB] reset mid-operation");
    applyStimulus(64'hC0, 64'hD0, 32'h4);
    applyStimulus(64'hC1, 64'hD1, 32'h4);
    applyStimulus(64'hC2, 64'hD2, 32'h4);
    waitReq(32'h1C);
    checkOutput("pre_reset_count", count, 2);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_reset_req_valid", cfg_req_valid, 0);
    checkOutput("mid_reset_count", count, 0);
    checkOutput("mid_reset_busy", busy, 0);
    checkOutput("mid_reset_ready", desc_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    snap = n_cpl;
    repeat (20) @(negedge clk);
    #3;
    checkOutput("post_reset_no_cpl", n_cpl, snap);
    checkOutput("post_reset_idle", busy, 0);

    // Recovery after reset.
    applyStimulus(64'h1_2345_6789, 64'h9_8765_4321, 32'h33);
    waitCpl(n);
    checkOutput("recover_latency", n, 14);
    checkOutput("recover_status", cpl_status, 0);

    repeat (5) @(negedge clk);
    #3;
    checkOutput("all_completed", cpl_idx, n_push);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
